// File: rtl/ledarray_pkg.sv
// Shared definitions for the LED-array serial link receiver.
package ledarray_pkg;

  // Receiver frame state: waiting for a start, or collecting bits.
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Bits in a position/value frame: 8 pos + 8 value + trailing framing bit.
  localparam int WORD_BITS = 17;
  // Bits in a command frame: 8 command + trailing framing bit.
  localparam int CMD_BITS = 9;
  // Position reported for command frames.
  localparam logic [7:0] CMD_POS = 8'hFF;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus one history register for an idle-high
// asynchronous link signal. cur is the synchronized sample, prev is the
// sample from the cycle before, so callers can detect edges and levels.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic cur,
  output logic prev
);

  logic meta;

  // Shift the pin level through the synchronizer and into the history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: reset to the link's idle-high level, otherwise reset release
      // would look like a falling edge and fake a start or bit event.
      meta <= 1'b1;
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a true three-stage chain;
      // blocking ones would collapse it into a single flop.
      meta <= async_in;
      cur  <= meta;
      prev <= cur;
    end
  end

endmodule

// File: rtl/readpixels.sv
// Receiver for the LED-array serial link. Start and stop are d_in edges
// while d_clk is high; each rising d_clk carries one data bit, LSB first.
// A 17-bit frame yields pos/value, a 9-bit frame yields a command byte.
module readpixels
  import ledarray_pkg::*;
#(
  parameter int CLK_IN_RATE_HZ = 12_000_000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_clk,
  input  logic       d_in,
  output logic [7:0] pos,
  output logic [7:0] value,
  output logic       is_cmd,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // The clock rate only documents the intended system; reject nonsense.
  if (CLK_IN_RATE_HZ <= 0) begin : g_bad_rate
    $error("readpixels: CLK_IN_RATE_HZ must be positive");
  end

  logic sc, pc, sd, pd;
  logic start_det, stop_det, bit_det;
  logic ev_start, ev_stop, ev_bit, ev_val;

  state_t                 state;
  logic [4:0]             bit_cnt;
  logic [WORD_BITS-1:0]   bits;
  logic [TW-1:0]          timer;

  sync_edge u_sync_clk (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (d_clk),
    .cur      (sc),
    .prev     (pc)
  );

  sync_edge u_sync_data (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (d_in),
    .cur      (sd),
    .prev     (pd)
  );

  // Link conditions: data edges with the clock steady high frame a
  // transfer; a clock rising edge carries a bit.
  assign start_det = pc & sc & pd & ~sd;
  assign stop_det  = pc & sc & ~pd & sd;
  assign bit_det   = ~pc & sc;

  // Register the detected events so the frame logic sees clean one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
      ev_bit   <= 1'b0;
      ev_val   <= 1'b0;
    end else begin
      ev_start <= start_det;
      ev_stop  <= stop_det;
      ev_bit   <= bit_det;
      ev_val   <= sd;
    end
  end

  // Frame state machine: collect bits, decode on stop, abort on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bits      <= '0;
      timer     <= '0;
      pos       <= '0;
      value     <= '0;
      is_cmd    <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ev_start) begin
            state   <= RECV;
            bit_cnt <= '0;
            bits    <= '0;
            timer   <= '0;
          end
        end
        RECV: begin
          if (ev_start) begin
            // Repeated start: drop what we have and begin a fresh frame.
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            bits      <= '0;
            timer     <= '0;
          end else if (ev_stop) begin
            state <= IDLE;
            if (bit_cnt == 5'(WORD_BITS) && !bits[WORD_BITS-1]) begin
              pos    <= bits[7:0];
              value  <= bits[15:8];
              is_cmd <= 1'b0;
              valid  <= 1'b1;
            end else if (bit_cnt == 5'(CMD_BITS) && !bits[CMD_BITS-1]) begin
              pos    <= CMD_POS;
              value  <= bits[7:0];
              is_cmd <= 1'b1;
              valid  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (ev_bit) begin
            if (bit_cnt < 5'(WORD_BITS)) begin
              bits[bit_cnt] <= ev_val;
            end
            if (bit_cnt != 5'd31) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
            timer <= '0;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_readpixels.sv
// Self-checking bench for readpixels: table-driven frames, hand-written
// multi-cycle sequences and randomized frames against a frame-level model.
module tb_readpixels;

  localparam int T_OUT = 300;  // shortened timeout for a quick run
  localparam int H     = 3;    // clk cycles per link phase

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_clk = 1'b1;
  logic       d_in  = 1'b1;
  logic [7:0] pos, value;
  logic       is_cmd, valid, frame_err, busy;

  readpixels #(
    .CLK_IN_RATE_HZ (12_000_000),
    .TIMEOUT_CYCLES (T_OUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_clk     (d_clk),
    .d_in      (d_in),
    .pos       (pos),
    .value     (value),
    .is_cmd    (is_cmd),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_miss = 0;
  int n_valid = 0, n_err = 0, n_both = 0;
  int v_cyc = -1, e_cyc = -1, stop_cyc = 0, rise_cyc = 0;
  logic [16:0] got_q[$];

  // Observe output pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        n_valid++;
        v_cyc = cyc;
        got_q.push_back({is_cmd, value, pos});
      end
      if (frame_err) begin
        n_err++;
        e_cyc = cyc;
      end
      if (valid && frame_err) n_both++;
    end
  end

  typedef struct {
    logic       ok;
    logic [7:0] pos;
    logic [7:0] value;
    logic       cmd;
  } res_t;

  typedef struct {
    int          nbits;
    logic [63:0] word;
    logic        exp_ok;
    logic [7:0]  exp_pos;
    logic [7:0]  exp_value;
    logic        exp_cmd;
  } vec_t;

  // Frame-level reference: what the outputs must show after a frame of
  // nbits bits (LSB first) terminated by a stop.
  function automatic res_t model(input int nbits, input logic [63:0] word, input res_t prev);
    res_t r;
    r    = prev;
    r.ok = 1'b0;
    if (nbits == 17 && word[16] == 1'b0) begin
      r.ok = 1'b1; r.pos = word[7:0]; r.value = word[15:8]; r.cmd = 1'b0;
    end else if (nbits == 9 && word[8] == 1'b0) begin
      r.ok = 1'b1; r.pos = 8'hFF; r.value = word[7:0]; r.cmd = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    n_valid = 0; n_err = 0; v_cyc = -1; e_cyc = -1;
    got_q.delete();
  endtask

  task automatic link_start();
    d_in = 1'b0;
    idle(H);
  endtask

  task automatic link_bit(input logic b);
    d_clk = 1'b0;
    idle(H);
    d_in = b;
    idle(H);
    d_clk = 1'b1;
    rise_cyc = cyc;
    idle(H);
  endtask

  task automatic link_stop();
    d_in = 1'b1;
    stop_cyc = cyc;
    idle(H);
  endtask

  task automatic send_bits(input int nbits, input logic [63:0] word);
    for (int i = 0; i < nbits; i++) link_bit(word[i]);
  endtask

  task automatic send_frame(input int nbits, input logic [63:0] word);
    link_start();
    send_bits(nbits, word);
    link_stop();
  endtask

  // Let the last frame drain, then compare pulses, latency and outputs.
  task automatic check_frame(input string tag, input logic ok, input logic [7:0] p,
                             input logic [7:0] v, input logic c);
    idle(12);
    check({tag, "_valid_cnt"}, n_valid, ok ? 1 : 0);
    check({tag, "_err_cnt"}, n_err, ok ? 0 : 1);
    if (ok) check({tag, "_valid_lat"}, v_cyc - stop_cyc, 4);
    else    check({tag, "_err_lat"}, e_cyc - stop_cyc, 4);
    check({tag, "_pos"}, pos, p);
    check({tag, "_value"}, value, v);
    check({tag, "_is_cmd"}, is_cmd, c);
    check({tag, "_busy"}, busy, 0);
  endtask

  vec_t vecs[10];
  res_t exp_r;

  initial begin
    vecs[0] = '{17, 64'h0_A305, 1'b1, 8'h05, 8'hA3, 1'b0};
    vecs[1] = '{9,  64'h08F,    1'b1, 8'hFF, 8'h8F, 1'b1};
    vecs[2] = '{12, 64'h3A5,    1'b0, 8'hFF, 8'h8F, 1'b1};
    vecs[3] = '{17, 64'h0_FF01, 1'b1, 8'h01, 8'hFF, 1'b0};
    vecs[4] = '{10, 64'h0AA,    1'b0, 8'h01, 8'hFF, 1'b0};
    vecs[5] = '{0,  64'h0,      1'b0, 8'h01, 8'hFF, 1'b0};
    vecs[6] = '{35, 64'h1_5555_5554, 1'b0, 8'h01, 8'hFF, 1'b0};
    vecs[7] = '{8,  64'h07E,    1'b0, 8'h01, 8'hFF, 1'b0};
    vecs[8] = '{17, 64'h0_0000, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[9] = '{18, 64'h0_1234, 1'b0, 8'h00, 8'h00, 1'b0};

    // Reset state.
    idle(3);
    check("rst_pos", pos, 0);
    check("rst_value", value, 0);
    check("rst_is_cmd", is_cmd, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(10);
    check("rel_no_valid", n_valid, 0);
    check("rel_no_err", n_err, 0);
    check("rel_busy", busy, 0);

    // Table of frames.
    for (int i = 0; i < 10; i++) begin
      clear_mon();
      send_frame(vecs[i].nbits, vecs[i].word);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_ok, vecs[i].exp_pos,
                  vecs[i].exp_value, vecs[i].exp_cmd);
    end

    // Repeated start after 6 bits, then a full frame 01/FF.
    clear_mon();
    link_start();
    send_bits(6, 64'h25);
    link_start();
    idle(6);
    check("rs_busy", busy, 1);
    check("rs_err_early", n_err, 1);
    send_bits(17, 64'h0_FF01);
    link_stop();
    idle(12);
    check("rs_err_cnt", n_err, 1);
    check("rs_valid_cnt", n_valid, 1);
    check("rs_order", (v_cyc > e_cyc) ? 1 : 0, 1);
    check("rs_pos", pos, 8'h01);
    check("rs_value", value, 8'hFF);
    check("rs_is_cmd", is_cmd, 0);

    // Back-to-back frames with only the stop/start gap between them.
    clear_mon();
    send_frame(17, 64'h0_5A3C);
    send_frame(9, 64'h0C3);
    idle(12);
    check("b2b_valid_cnt", n_valid, 2);
    check("b2b_err_cnt", n_err, 0);
    if (got_q.size() == 2) begin
      check("b2b_first", got_q[0], {1'b0, 8'h5A, 8'h3C});
      check("b2b_second", got_q[1], {1'b1, 8'hC3, 8'hFF});
    end

    // Reset in the middle of a frame.
    clear_mon();
    link_start();
    send_bits(5, 64'h0D);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pos", pos, 0);
    check("mid_rst_value", value, 0);
    check("mid_rst_is_cmd", is_cmd, 0);
    check("mid_rst_busy", busy, 0);
    d_clk = 1'b1;
    d_in  = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check("mid_no_valid", n_valid, 0);
    check("mid_no_err", n_err, 0);
    check("mid_busy_after", busy, 0);

    // Randomized frames against the reference model.
    exp_r = '{1'b0, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < 30; i++) begin
      int          nb;
      logic [63:0] w;
      case ($urandom_range(0, 3))
        0:       nb = 17;
        1:       nb = 9;
        default: nb = $urandom_range(0, 22);
      endcase
      w = {$urandom, $urandom};
      if (nb > 0) w[nb-1] = 1'b0;  // a stop needs d_in low before it
      exp_r = model(nb, w, exp_r);
      clear_mon();
      send_frame(nb, w);
      check_frame($sformatf("rnd%0d_n%0d", i, nb), exp_r.ok, exp_r.pos, exp_r.value, exp_r.cmd);
    end

    // Timeout: three bits, then the link goes quiet.
    clear_mon();
    link_start();
    send_bits(3, 64'h5);
    check("to_busy", busy, 1);
    for (int k = 0; k < T_OUT + 40 && n_err == 0; k++) idle(1);
    check("to_err_cnt", n_err, 1);
    check("to_err_lat", e_cyc - rise_cyc, T_OUT + 4);
    check("to_no_valid", n_valid, 0);
    check("to_busy_after", busy, 0);
    check("to_pos_held", pos, exp_r.pos);

    check("never_both", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/readpixels.md
READPIXELS -- requirements
Module: readpixels

Interface
REQ-001 Parameter CLK_IN_RATE_HZ, default 12_000_000: system clock rate, documentation only.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: clk cycles without a synchronized d_clk edge that abort an open frame.
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 d_clk  input  1  serial clock from the LED-array link; asynchronous to clk; idles high.
REQ-006 d_in  input  1  serial data from the link; asynchronous to clk; idles high.
REQ-007 pos  output  8  received position byte; 8'hFF for command frames.
REQ-008 value  output  8  received value byte, or the command byte.
REQ-009 is_cmd  output  1  qualifies pos/value; 1 = 8-bit command frame, 0 = 16-bit pos/value frame.
REQ-010 valid  output  1  one-cycle pulse; pos/value/is_cmd are valid in the same cycle.
REQ-011 frame_err  output  1  one-cycle pulse; frame discarded.
REQ-012 busy  output  1  high while a frame is open (state RECV).

Function
REQ-013 d_clk and d_in SHALL each pass through a 2-flop synchronizer, then one history register; detection uses the current and previous synchronized samples (sc/pc for clock, sd/pd for data).
REQ-014 Start = pd=1, sd=0, with pc=1 and sc=1.
REQ-015 Stop = pd=0, sd=1, with pc=1 and sc=1.
REQ-016 Bit event = pc=0, sc=1; the bit value is sd in that cycle.
REQ-017 States: IDLE, RECV.
REQ-018 Transition IDLE->RECV on start; clear the 5-bit bit counter and the shift register.
REQ-019 Bit events and stops in IDLE SHALL be ignored.
REQ-020 In RECV, each bit event SHALL store the bit LSB-first at index = bit counter and increment the counter.
REQ-021 Counter saturates at 31; bits with index beyond 16 are dropped.
REQ-022 Stop in RECV with count 17 and bit 16 = 0: pos = bits[7:0], value = bits[15:8], is_cmd=0, pulse valid, go to IDLE.
REQ-023 Stop in RECV with count 9 and bit 8 = 0: value = bits[7:0], pos = 8'hFF, is_cmd=1, pulse valid, go to IDLE.
REQ-024 Any other count, or the trailing framing bit = 1: pulse frame_err, leave pos/value/is_cmd unchanged, go to IDLE.
REQ-025 Start in RECV (repeated start): pulse frame_err, discard, restart reception with counter cleared, stay in RECV.
REQ-026 In RECV with TIMEOUT_CYCLES consecutive cycles and no bit event: pulse frame_err, go to IDLE.
REQ-027 The timeout counter SHALL clear on entry to RECV and on every bit event.
REQ-028 valid and frame_err SHALL never assert in the same cycle.
REQ-029 pos/value/is_cmd SHALL hold between valid pulses.
REQ-030 Latency: valid/frame_err SHALL assert exactly 4 clk edges after the d_in stop transition at the pin, provided synchronizer setup is met.
REQ-031 Back-to-back frames with no idle gap beyond the stop condition SHALL be received without loss.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE.
REQ-033 Reset values: pos=0, value=0, is_cmd=0, valid=0, frame_err=0, busy=0, counters=0.
REQ-034 Synchronizer and history flops SHALL reset to 1 (idle-high), so reset release never produces a false start or bit event.
REQ-035 Reset mid-frame SHALL discard the frame with no valid or frame_err pulse.

Structure
REQ-036 Shared package ledarray_pkg SHALL hold: state enum (IDLE, RECV), WORD_BITS=17, CMD_BITS=9, CMD_POS=8'hFF.
REQ-037 Sub-module sync_edge SHALL provide the 2-flop sync plus history register, with reset value 1.
REQ-038 sync_edge SHALL be instantiated once for d_clk and once for d_in.

Verification
REQ-039 Writer-timed frame, pos=8'h05, value=8'hA3, 17 clocks with framing bit 0, then stop -> single valid, pos=05, value=A3, is_cmd=0, 4 clk after stop.
REQ-040 Command frame, 9 clocks of byte 8'h8F plus framing bit 0, then stop -> valid, pos=FF, value=8F, is_cmd=1.
REQ-041 Frame of 12 clocks then stop -> frame_err pulse, no valid, outputs keep previous values.
REQ-042 Start, 6 bits, then repeated start and a full 17-bit frame with pos=01, value=FF -> one frame_err, then valid with 01/FF.
REQ-043 Start, 3 bits, then d_clk held for TIMEOUT_CYCLES -> frame_err at expiry, busy falls; rst_n pulsed mid-frame -> no pulses, outputs 0.
